debug_unit_transmit: RTL and testbench

DEBUG_UNIT_TRANSMIT -- requirements
Module: debug_unit_transmit

---
 rtl/debug_unit_transmit.sv | 162 ++++++++++++++++
 tb/tb_debug_unit_transmit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit_transmit.sv
// Debug unit transmitter: on a trigger, snapshots PC and cycle count, then
// streams a frame over the UART byte interface. The frame is header 0xAA,
// PC, cycle count, all registers, then N_MEM_WORDS data-memory words, with
// each word sent MSB first.
module debug_unit_transmit #(
  parameter int N_BITS       = 8,
  parameter int N_BITS_REG   = 5,
  parameter int N_BITS_INSTR = 32,
  parameter int N_MEM_WORDS  = 32,
  parameter int NB_STATE     = 3
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_send,
  input  logic [N_BITS_INSTR-1:0] i_pc,
  input  logic [N_BITS_INSTR-1:0] i_cycle_count,
  output logic [N_BITS_REG-1:0]   o_reg_addr,
  input  logic [N_BITS_INSTR-1:0] i_reg_data,
  output logic [4:0]              o_mem_addr,
  input  logic [N_BITS_INSTR-1:0] i_mem_data,
  output logic [N_BITS-1:0]       o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [NB_STATE-1:0]     o_state
);

  localparam int N_BITS_MEM = 5;
  localparam int NUM_REGS   = 2 ** N_BITS_REG;

  // Word index layout: 0 = PC, 1 = cycle count, then registers, then memory.
  localparam logic [6:0] REG_BASE  = 7'd2;
  localparam logic [6:0] MEM_BASE  = 7'(2 + NUM_REGS);
  localparam logic [6:0] LAST_WORD = 7'(2 + NUM_REGS + N_MEM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    HEADER = 3'b001,
    FETCH  = 3'b010,
    LATCH  = 3'b011,
    SEND   = 3'b100,
    WAIT   = 3'b101,
    DONE   = 3'b110
  } state_t;

  state_t                  state;
  logic [6:0]              word_idx;
  logic [6:0]              next_idx;
  logic [1:0]              byte_cnt;
  logic                    header_word;
  logic [N_BITS_INSTR-1:0] pc_snap;
  logic [N_BITS_INSTR-1:0] count_snap;
  logic [N_BITS_INSTR-1:0] buffer;

  function automatic logic is_reg_word(input logic [6:0] idx);
    return (idx >= REG_BASE) && (idx < MEM_BASE);
  endfunction

  function automatic logic is_mem_word(input logic [6:0] idx);
    return idx >= MEM_BASE;
  endfunction

  function automatic logic [N_BITS_REG-1:0] reg_offset(input logic [6:0] idx);
    return N_BITS_REG'(idx - REG_BASE);
  endfunction

  function automatic logic [N_BITS_MEM-1:0] mem_offset(input logic [6:0] idx);
    return N_BITS_MEM'(idx - MEM_BASE);
  endfunction

  assign next_idx = word_idx + 7'd1;
  assign o_state  = NB_STATE'(state);

  // Frame sequencer: addresses are presented on entry to FETCH so that
  // synchronous-read storage has data ready by the time LATCH captures it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      word_idx    <= '0;
      byte_cnt    <= '0;
      header_word <= 1'b0;
      pc_snap     <= '0;
      count_snap  <= '0;
      buffer      <= '0;
      o_reg_addr  <= '0;
      o_mem_addr  <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_send) begin
            pc_snap    <= i_pc;
            count_snap <= i_cycle_count;
            word_idx   <= '0;
            byte_cnt   <= '0;
            o_busy     <= 1'b1;
            state      <= HEADER;
          end
        end
        HEADER: begin
          buffer      <= {N_BITS'(8'hAA), {(N_BITS_INSTR - N_BITS){1'b0}}};
          header_word <= 1'b1;
          byte_cnt    <= '0;
          state       <= SEND;
        end
        FETCH: begin
          if (is_reg_word(word_idx)) o_reg_addr <= reg_offset(word_idx);
          if (is_mem_word(word_idx)) o_mem_addr <= mem_offset(word_idx);
          state <= LATCH;
        end
        LATCH: begin
          if (word_idx == 7'd0)           buffer <= pc_snap;
          else if (word_idx == 7'd1)      buffer <= count_snap;
          else if (is_reg_word(word_idx)) buffer <= i_reg_data;
          else                            buffer <= i_mem_data;
          byte_cnt <= '0;
          state    <= SEND;
        end
        SEND: begin
          o_tx_data  <= buffer[N_BITS_INSTR-1 -: N_BITS];
          o_tx_start <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) begin
            buffer   <= buffer << N_BITS;
            byte_cnt <= byte_cnt + 2'd1;
            if (header_word) begin
              header_word <= 1'b0;
              state       <= FETCH;
            end else if (byte_cnt != 2'd3) begin
              state <= SEND;
            end else if (word_idx != LAST_WORD) begin
              word_idx <= next_idx;
              if (is_reg_word(next_idx)) o_reg_addr <= reg_offset(next_idx);
              if (is_mem_word(next_idx)) o_mem_addr <= mem_offset(next_idx);
              state <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit_transmit.sv
// Self-checking bench for debug_unit_transmit: a UART responder, register
// and memory models, and a byte scoreboard filled when each frame is triggered.
module tb_debug_unit_transmit;

  logic        clock = 1'b0;
  logic        reset;
  logic        send;
  logic        tx_done;
  logic [31:0] pc;
  logic [31:0] cyc;
  logic [31:0] reg_data;
  logic [31:0] mem_data;
  logic [4:0]  reg_addr;
  logic [4:0]  mem_addr;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  int          total_bytes = 0;
  int          done_count = 0;
  int          uart_cnt = 0;
  int          spur_state = -1;
  logic [7:0]  sent_byte = 8'h00;
  logic [31:0] last4 = 32'h0;

  debug_unit_transmit dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_send        (send),
    .i_pc          (pc),
    .i_cycle_count (cyc),
    .o_reg_addr    (reg_addr),
    .i_reg_data    (reg_data),
    .o_mem_addr    (mem_addr),
    .i_mem_data    (mem_data),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .i_tx_done     (tx_done),
    .o_busy        (busy),
    .o_done        (done),
    .o_state       (state)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Synchronous-read register file and data memory models.
  always @(posedge clock) begin
    reg_data <= 32'(reg_addr) * 32'h01010101;
    mem_data <= 32'hDEAD0000 + 32'(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic push_frame(input logic [31:0] p, input logic [31:0] c);
    exp_q.push_back(8'hAA);
    push_word(p);
    push_word(c);
    for (int r = 0; r < 32; r++) push_word(32'(r) * 32'h01010101);
    for (int k = 0; k < 32; k++) push_word(32'hDEAD0000 + 32'(k));
  endtask

  // One clock period: sample at negedge, run UART responder and scoreboard.
  task automatic tick();
    logic [7:0] want;
    @(negedge clock);
    tx_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) begin
        tx_done = 1'b1;
        check("tx_data_stable", {24'h0, tx_data}, {24'h0, sent_byte});
      end
    end
    if (spur_state >= 0 && state == 3'(spur_state)) begin
      tx_done = 1'b1;
      spur_state = -1;
    end
    if (tx_start) begin
      total_bytes++;
      last4 = {last4[23:0], tx_data};
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("[TB] FAIL extra_byte observed=%h expected=none", tx_data);
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("tx_byte", {24'h0, tx_data}, {24'h0, want});
      end
      sent_byte = tx_data;
      uart_cnt = 10;
    end
    if (done) done_count++;
  endtask

  task automatic trigger(input logic [31:0] p, input logic [31:0] c);
    pc = p;
    cyc = c;
    send = 1'b1;
    tick();
    send = 1'b0;
    pc = 32'h12345678;
    cyc = 32'hCAFEF00D;
  endtask

  task automatic run_frame(input bit resend_at_50);
    int  base_b;
    int  base_d;
    bit  resent;
    base_b = total_bytes;
    base_d = done_count;
    resent = 1'b0;
    for (int c = 0; c < 6000 && done_count == base_d; c++) begin
      tick();
      if (resend_at_50 && !resent && total_bytes - base_b == 50) begin
        send = 1'b1;
        tick();
        send = 1'b0;
        resent = 1'b1;
      end
    end
    repeat (20) tick();
    check("frame_bytes", 32'(total_bytes - base_b), 32'd265);
    check("frame_done_pulses", 32'(done_count - base_d), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("last_word", last4, 32'hDEAD001F);
    check("idle_after_frame", {29'h0, state}, 32'd0);
    check("busy_after_frame", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int base_b;
    int base_d;
    reset = 1'b1;
    send = 1'b0;
    tx_done = 1'b0;
    pc = 32'h0;
    cyc = 32'h0;

    // Reset, with a trigger coincident with reset that must be ignored.
    repeat (2) tick();
    send = 1'b1;
    tick();
    send = 1'b0;
    check("rst_state", {29'h0, state}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_tx_start", {31'h0, tx_start}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_tx_data", {24'h0, tx_data}, 32'd0);
    check("rst_reg_addr", {27'h0, reg_addr}, 32'd0);
    check("rst_mem_addr", {27'h0, mem_addr}, 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    check("send_with_reset_ignored", {29'h0, state}, 32'd0);

    // Spurious tx_done while idle.
    spur_state = 0;
    repeat (3) tick();
    check("spur_idle_state", {29'h0, state}, 32'd0);
    check("spur_idle_busy", {31'h0, busy}, 32'd0);
    check("spur_idle_no_bytes", 32'(total_bytes), 32'd0);

    // Frame 1: PC changed after trigger, spurious done in FETCH, resend at byte 50.
    $display("[TB] frame 1");
    push_frame(32'h00400010, 32'h0000002A);
    spur_state = 2;
    trigger(32'h00400010, 32'h0000002A);
    check("header_state", {29'h0, state}, 32'd1);
    check("busy_in_frame", {31'h0, busy}, 32'd1);
    run_frame(1'b1);

    // Frame 2: reset while waiting on byte 100.
    $display("[TB] frame 2 with reset");
    push_frame(32'h00000444, 32'h00000555);
    base_b = total_bytes;
    base_d = done_count;
    trigger(32'h00000444, 32'h00000555);
    for (int c = 0; c < 3000 && total_bytes - base_b < 100; c++) tick();
    check("reach_byte_100", 32'(total_bytes - base_b), 32'd100);
    check("pre_reset_wait", {29'h0, state}, 32'd5);
    reset = 1'b1;
    tick();
    check("mid_reset_state", {29'h0, state}, 32'd0);
    check("mid_reset_busy", {31'h0, busy}, 32'd0);
    check("mid_reset_tx_start", {31'h0, tx_start}, 32'd0);
    uart_cnt = 0;
    exp_q.delete();
    reset = 1'b0;
    repeat (30) tick();
    check("abandoned_no_bytes", 32'(total_bytes - base_b), 32'd100);
    check("abandoned_no_done", 32'(done_count - base_d), 32'd0);

    // Frame 3: restart after the abandoned frame begins again at the header.
    $display("[TB] frame 3");
    push_frame(32'h00000100, 32'h00000999);
    trigger(32'h00000100, 32'h00000999);
    run_frame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
